mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit (Moore FSM). Sequences the single shared datapath (PC, IR, GRF, EXT, ALU, DM) through fetch, decode, execute, memory and writeback steps.
- Decodes IR opcode/funct. Drives every datapath write enable and mux select, including EXTop for the immediate extender.
- Supported subset: addu, subu, jr, ori, addiu, lui, lw, sw, beq, j, jal.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU equality flag, valid in the BR state.
- PCWr  out  1  PC write enable.
- IRWr  out  1  IR write enable.
- RegWr  out  1  GRF write enable.
- MemWr  out  1  DM write enable.
- EXTop  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
- ALUop  out  3  000 add, 001 sub, 010 or.
- ALUSrc  out  1  0 = GRF rt, 1 = EXT output.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALU result, 01 DM data, 10 PC (already PC+4).
- NPCop  out  2  00 PC+4, 01 branch target, 10 j/jal target, 11 GRF rs.
- illegal  out  1  unsupported instruction flag, one-cycle pulse.
- instr_cnt  out  CNT_W  count of retired instructions.
- state  out  4  current state, for debug.

Behaviour:
- States (4-bit encoding): FETCH=0, DECODE=1, MA=2, MR=3, MWB=4, MW=5, EXE=6, RWB=7, BR=8, JMP=9. Codes 10-15 are unreachable; if entered, go to FETCH.
- Reset (async, reset==0): state=FETCH, instr_cnt=0.
  - While reset is low, all outputs are 0, except state, which shows 0.
  - Reset asserted mid-instruction abandons it immediately. No write enable may glitch high during reset.
- Transitions:
  - FETCH -> DECODE, always.
  - DECODE -> MA for lw/sw.
  - DECODE -> EXE for addu/subu/ori/addiu/lui.
  - DECODE -> BR for beq.
  - DECODE -> JMP for j/jal/jr.
  - DECODE -> FETCH for anything else, with illegal=1 for that DECODE cycle.
  - MA -> MR (lw) or MW (sw).
  - MR -> MWB.
  - EXE -> RWB.
  - MWB, MW, RWB, BR, JMP -> FETCH.
- Outputs are purely a function of the registered state plus op/funct (Moore with decode). Any output not listed for a state is 0.
  - FETCH: PCWr=1, IRWr=1, NPCop=00.
  - DECODE: no enables. EXTop=01 (sign-extend, for branch-offset precompute).
  - MA: ALUop=000, ALUSrc=1, EXTop=01.
  - MR: no enables.
  - MWB: RegWr=1, RegDst=00, MemtoReg=01.
  - MW: MemWr=1. ALUop/ALUSrc/EXTop held as in MA.
  - EXE / RWB, by instruction; RWB also asserts RegWr=1:
    - addu: ALUop=000, ALUSrc=0, RegDst=01.
    - subu: ALUop=001, ALUSrc=0, RegDst=01.
    - ori: ALUop=010, ALUSrc=1, EXTop=00, RegDst=00.
    - addiu: ALUop=000, ALUSrc=1, EXTop=01, RegDst=00.
    - lui: ALUop=010, ALUSrc=1, EXTop=10, RegDst=00 (rs is $0, so the OR passes imm<<16).
  - BR: ALUop=001, ALUSrc=0, EXTop=01, NPCop=01, PCWr=zero.
  - JMP:
    - j: PCWr=1, NPCop=10.
    - jal: as j, plus RegWr=1, RegDst=10, MemtoReg=10.
    - jr: PCWr=1, NPCop=11.
- R-type decode: op=000000 with funct 100001 addu, 100011 subu, 001000 jr. Any other funct is illegal.
- Opcodes: ori 001101, addiu 001001, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- op/funct must be sampled from the IR, which is stable after FETCH. In FETCH the controller ignores op/funct.
- Latency (cycles incl. FETCH):
  - lw 5.
  - sw, R-type, ori, addiu, lui 4.
  - beq, j, jal, jr 3.
  - illegal 2.
- instr_cnt increments on the last cycle of each legal instruction (MWB, MW, RWB, BR taken or not, JMP). It wraps modulo 2^CNT_W and does not count illegal instructions.

Decomposition:
- Shared package/header holds:
  - state codes;
  - opcode/funct constants;
  - EXTop, ALUop, RegDst, MemtoReg and NPCop encodings (shared with the EXT, ALU and NPC blocks).
- One natural sub-module, mc_decode: combinational op/funct -> one-hot instruction class plus illegal. The FSM and output logic remain in mc_ctrl.

Test Plan:
- Hold reset=0 for 3 cycles with op=100011 -> all enables 0, state=0, instr_cnt=0. Release -> next cycle FETCH with PCWr=IRWr=1.
- lw (op=100011) -> states 0,1,2,3,4. RegWr=1 only in state 4, with MemtoReg=01. instr_cnt 0->1.
- ori (op=001101) -> EXTop=00 and ALUop=010 in states 6 and 7. lui (op=001111) -> EXTop=10. addiu -> EXTop=01. RegWr only in state 7.
- beq with zero=1, then again with zero=0 -> state 8 both times. PCWr=1 and NPCop=01 only when zero=1. Both retire (count +2).
- jal -> state 9 with PCWr=1, RegWr=1, RegDst=10, MemtoReg=10. jr (op=0, funct=001000) -> NPCop=11, RegWr=0.
- op=111111 -> illegal=1 in DECODE, then FETCH, instr_cnt unchanged. Separately, drop reset in MW -> MemWr falls immediately and state=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and the datapath blocks
// it steers (EXT, ALU, NPC, GRF write-port muxes).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MA     = 4'd2,
        S_MR     = 4'd3,
        S_MWB    = 4'd4,
        S_MW     = 4'd5,
        S_EXE    = 4'd6,
        S_RWB    = 4'd7,
        S_BR     = 4'd8,
        S_JMP    = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_DM   = 2'b01;
    localparam logic [1:0] M2R_PC   = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

    // One-hot instruction class; all-zero means unsupported.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic addiu;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder: one-hot instruction class plus an
// unsupported-instruction flag.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output instr_cls_t cls,
    output logic       illegal
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls.addu = 1'b1;
                    FN_SUBU: cls.subu = 1'b1;
                    FN_JR:   cls.jr   = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:   cls.ori   = 1'b1;
            OP_ADDIU: cls.addiu = 1'b1;
            OP_LUI:   cls.lui   = 1'b1;
            OP_LW:    cls.lw    = 1'b1;
            OP_SW:    cls.sw    = 1'b1;
            OP_BEQ:   cls.beq   = 1'b1;
            OP_J:     cls.j     = 1'b1;
            OP_JAL:   cls.jal   = 1'b1;
            default:  ;
        endcase
    end

    assign illegal = ~|cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing the shared datapath,
// with per-state decode of op/funct into datapath enables and selects.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWr,
    output logic             MemWr,
    output logic [1:0]       EXTop,
    output logic [2:0]       ALUop,
    output logic             ALUSrc,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       NPCop,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    instr_cls_t       cls;
    logic             dec_illegal;
    logic             retire;

    logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src, ill;
    logic [1:0] ext_op, reg_dst, mem_to_reg, npc_op;
    logic [2:0] alu_op;

    mc_decode u_decode (
        .op      (op),
        .funct   (funct),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    assign retire = (state_reg == S_MWB) || (state_reg == S_MW) || (state_reg == S_RWB) ||
                    (state_reg == S_BR)  || (state_reg == S_JMP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (retire)
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (cls.lw || cls.sw)
                    state_next = S_MA;
                else if (cls.addu || cls.subu || cls.ori || cls.addiu || cls.lui)
                    state_next = S_EXE;
                else if (cls.beq)
                    state_next = S_BR;
                else if (cls.j || cls.jal || cls.jr)
                    state_next = S_JMP;
                else
                    state_next = S_FETCH;
            end
            S_MA:     state_next = cls.lw ? S_MR : S_MW;
            S_MR:     state_next = S_MWB;
            S_EXE:    state_next = S_RWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        ext_op     = EXT_ZERO;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALU;
        npc_op     = NPC_PC4;
        ill        = 1'b0;
        case (state_reg)
            S_FETCH: begin
                pc_wr = 1'b1;
                ir_wr = 1'b1;
            end
            S_DECODE: begin
                ext_op = EXT_SIGN;
                ill    = dec_illegal;
            end
            S_MA, S_MW: begin
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                mem_wr  = (state_reg == S_MW);
            end
            S_MWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = M2R_DM;
            end
            S_EXE, S_RWB: begin
                // ALU operands stay steered through writeback so the result is stable.
                reg_wr = (state_reg == S_RWB);
                if (cls.addu) begin
                    reg_dst = DST_RD;
                end else if (cls.subu) begin
                    alu_op  = ALU_SUB;
                    reg_dst = DST_RD;
                end else if (cls.ori) begin
                    alu_op  = ALU_OR;
                    alu_src = 1'b1;
                end else if (cls.addiu) begin
                    alu_src = 1'b1;
                    ext_op  = EXT_SIGN;
                end else if (cls.lui) begin
                    alu_op  = ALU_OR;
                    alu_src = 1'b1;
                    ext_op  = EXT_LUI;
                end
            end
            S_BR: begin
                alu_op = ALU_SUB;
                ext_op = EXT_SIGN;
                npc_op = NPC_BR;
                pc_wr  = zero;
            end
            S_JMP: begin
                pc_wr = 1'b1;
                if (cls.jr) begin
                    npc_op = NPC_RS;
                end else begin
                    npc_op = NPC_J;
                    if (cls.jal) begin
                        reg_wr     = 1'b1;
                        reg_dst    = DST_RA;
                        mem_to_reg = M2R_PC;
                    end
                end
            end
            default: ;
        endcase
    end

    // Gate with reset so nothing can assert while reset is held, even combinationally.
    assign PCWr     = reset & pc_wr;
    assign IRWr     = reset & ir_wr;
    assign RegWr    = reset & reg_wr;
    assign MemWr    = reset & mem_wr;
    assign ALUSrc   = reset & alu_src;
    assign illegal  = reset & ill;
    assign EXTop    = reset ? ext_op     : 2'b00;
    assign ALUop    = reset ? alu_op     : 3'b000;
    assign RegDst   = reset ? reg_dst    : 2'b00;
    assign MemtoReg = reset ? mem_to_reg : 2'b00;
    assign NPCop    = reset ? npc_op     : 2'b00;
    assign instr_cnt = cnt_reg;
    assign state     = state_reg;

endmodule
